xbus_dec: RTL and testbench

Parametrised data-bus decoder and interconnect between the controller data port and up to N_SLV memory-mapped peripherals. It replaces the fixed combinational select/read-mux in the top level with these features:
- per-slave base/mask regions
- a ready handshake, so slaves may insert wait states
- registered read data
- an error-capture register that records accesses to unmapped addresses and slave timeouts

It sits directly below `xctrl` in the top level; every peripheral (regf, prog, ps2, pushs, disp, gpo, oper, …) attaches to one slave channel.

---
 rtl/xbus_dec_pkg.sv | 17 +
 rtl/xbus_dec_if.sv | 33 +++
 rtl/xbus_dec_match.sv | 27 ++
 rtl/xbus_dec.sv | 180 ++++++++++++++++++
 tb/tb_xbus_dec.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_dec_pkg.sv
// Shared definitions for the xbus_dec data-bus decoder: FSM encoding,
// error-capture register layout and the default error-register address.
package xbus_dec_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   // Error-register flag positions, counted down from the data MSB.
   localparam int unsigned ErrValidOfs = 0;
   localparam int unsigned ErrToOfs    = 1;

   localparam logic [31:0] ErrAddrDefault = 32'h0000_03FF;

endpackage

// File: rtl/xbus_dec_if.sv
// Controller data port plus the slave-side bus of the xbus_dec interconnect.
// The decoder uses the slave modport; controller and peripherals use master.
interface xbus_dec_if #(
   parameter int unsigned N_SLV  = 8,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic                    data_sel;
   logic                    data_we;
   logic [ADDR_W-1:0]       data_addr;
   logic [DATA_W-1:0]       data_to_wr;
   logic [DATA_W-1:0]       data_to_rd;
   logic                    data_ready;

   logic [N_SLV-1:0]        slv_sel;
   logic                    slv_we;
   logic [ADDR_W-1:0]       slv_addr;
   logic [DATA_W-1:0]       slv_wdata;
   logic [N_SLV*DATA_W-1:0] slv_rdata;
   logic [N_SLV-1:0]        slv_ready;

   modport slave (
      input  data_sel, data_we, data_addr, data_to_wr, slv_rdata, slv_ready,
      output data_to_rd, data_ready, slv_sel, slv_we, slv_addr, slv_wdata
   );

   modport master (
      output data_sel, data_we, data_addr, data_to_wr, slv_rdata, slv_ready,
      input  data_to_rd, data_ready, slv_sel, slv_we, slv_addr, slv_wdata
   );

endinterface

// File: rtl/xbus_dec_match.sv
// Combinational address matcher: one-hot hit of the lowest-index slave whose
// masked base equals the masked address.
module xbus_dec_match #(
   parameter int unsigned                N_SLV    = 8,
   parameter int unsigned                ADDR_W   = 32,
   parameter logic [N_SLV*ADDR_W-1:0]    SLV_BASE = '0,
   parameter logic [N_SLV*ADDR_W-1:0]    SLV_MASK = '0
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [N_SLV-1:0]  hit_o,
   output logic              any_hit_o
);

   always_comb begin
      hit_o     = '0;
      any_hit_o = 1'b0;
      // Walk from the top so the lowest matching index overwrites the rest.
      for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
         if (((addr_i ^ SLV_BASE[i*ADDR_W +: ADDR_W]) & SLV_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
            hit_o     = '0;
            hit_o[i]  = 1'b1;
            any_hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/xbus_dec.sv
// Data-bus decoder/interconnect between the controller and N_SLV peripherals.
// Optional slave timeout is enabled with `define XBUS_DEC_TIMEOUT_EN.
module xbus_dec
   import xbus_dec_pkg::*;
#(
   parameter int unsigned             N_SLV    = 8,
   parameter int unsigned             ADDR_W   = 32,
   parameter int unsigned             DATA_W   = 32,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
   parameter logic [ADDR_W-1:0]       ERR_ADDR = ADDR_W'(ErrAddrDefault),
   parameter int unsigned             TIMEOUT  = 64
) (
   input logic         clk,
   input logic         rst,
   xbus_dec_if.slave   bus
);

   localparam int unsigned ErrAddrW = (ADDR_W < DATA_W - 2) ? ADDR_W : DATA_W - 2;

   if (N_SLV < 1 || N_SLV > 16 || TIMEOUT < 1) begin : g_bad_param
      $error("xbus_dec: N_SLV must be 1..16 and TIMEOUT at least 1");
   end

   state_e                state_q, state_d;
   logic [N_SLV-1:0]      sel_q, sel_d;
   logic                  we_q, we_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  err_valid_q;
   logic [ErrAddrW-1:0]   err_addr_q;
   logic                  err_to;

   logic [N_SLV-1:0]      hit, mux_sel, slv_sel;
   logic                  any_hit, rdy_hit, idle_req, is_err_addr;
   logic                  err_set, err_clr, timeout;
   logic [ErrAddrW-1:0]   err_src_addr;
   logic [DATA_W-1:0]     slv_mux, err_word;

   xbus_dec_match #(
      .N_SLV    (N_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_match (
      .addr_i    (bus.data_addr),
      .hit_o     (hit),
      .any_hit_o (any_hit)
   );

   assign idle_req    = (state_q == StIdle) && bus.data_sel;
   assign is_err_addr = (bus.data_addr == ERR_ADDR);
   assign mux_sel     = (state_q == StIdle) ? hit : sel_q;
   assign rdy_hit     = |(mux_sel & bus.slv_ready);

   always_comb begin
      slv_mux = '0;
      for (int unsigned i = 0; i < N_SLV; i++) begin
         if (mux_sel[i]) slv_mux |= bus.slv_rdata[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      err_word                           = '0;
      err_word[DATA_W-1-ErrValidOfs]     = err_valid_q;
      err_word[DATA_W-1-ErrToOfs]        = err_to;
      err_word[ErrAddrW-1:0]             = err_addr_q;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      slv_sel = '0;
      case (state_q)
         StIdle: begin
            if (bus.data_sel) begin
               we_d    = bus.data_we;
               sel_d   = hit;
               rdata_d = '0;
               if (is_err_addr) begin
                  state_d = StResp;
                  if (!bus.data_we) rdata_d = err_word;
               end else if (any_hit) begin
                  // The request cycle is the first select cycle, so a
                  // zero-wait slave completes without visiting WAIT.
                  slv_sel = hit;
                  if (rdy_hit) begin
                     state_d = StResp;
                     if (!bus.data_we) rdata_d = slv_mux;
                  end else begin
                     state_d = StWait;
                  end
               end else begin
                  state_d = StResp;
               end
            end
         end
         StWait: begin
            slv_sel = sel_q;
            if (rdy_hit) begin
               state_d = StResp;
               if (!we_q) rdata_d = slv_mux;
            end else if (timeout) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   assign err_clr = idle_req && is_err_addr && bus.data_we;
   assign err_set = (idle_req && !is_err_addr && !any_hit) || timeout;

`ifdef XBUS_DEC_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CntW-1:0]     cnt_q;
   logic [ErrAddrW-1:0] addr_q;
   logic                err_to_q;

   assign timeout      = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));
   assign err_src_addr = timeout ? addr_q : bus.data_addr[ErrAddrW-1:0];
   assign err_to       = err_to_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         addr_q   <= '0;
         err_to_q <= 1'b0;
      end else begin
         cnt_q <= (state_q == StWait) ? cnt_q + 1'b1 : '0;
         if (idle_req) addr_q <= bus.data_addr[ErrAddrW-1:0];
         if (err_clr) begin
            err_to_q <= 1'b0;
         end else if (err_set && !err_valid_q) begin
            err_to_q <= timeout;
         end
      end
   end
`else
   assign timeout      = 1'b0;
   assign err_src_addr = bus.data_addr[ErrAddrW-1:0];
   assign err_to       = 1'b0;
`endif

   // Only the first error is kept; a clear in the same cycle wins.
   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
      end else if (err_set && !err_valid_q) begin
         err_valid_q <= 1'b1;
         err_addr_q  <= err_src_addr;
      end
   end

   assign bus.slv_sel    = slv_sel;
   assign bus.slv_we     = bus.data_we;
   assign bus.slv_addr   = bus.data_addr;
   assign bus.slv_wdata  = bus.data_to_wr;
   assign bus.data_ready = (state_q == StResp);
   assign bus.data_to_rd = (state_q == StResp) ? rdata_q : '0;

endmodule

// File: tb/tb_xbus_dec.sv
// Self-checking bench for xbus_dec: behavioural slaves with programmable wait
// states and a queue of expected read data popped at each data_ready.
module tb_xbus_dec;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] ERRA = 32'h3FF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   xbus_dec_if #(.N_SLV(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   xbus_dec #(
      .N_SLV    (N),
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .SLV_BASE ({32'h200, 32'h100, 32'h200, 32'h000}),
      .SLV_MASK ({32'hFFF, 32'hF00, 32'hF00, 32'hF00}),
      .ERR_ADDR (ERRA),
      .TIMEOUT  (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          wait_cfg  [N];
   logic [31:0] rdata_cfg [N];
   logic [7:0]  sel_cnt   [N];
   logic [N-1:0] force_rdy;
   logic [31:0] exp_q [$];
   int total = 0;
   int bad = 0;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         sel_cnt[i] <= bus.slv_sel[i] ? ((sel_cnt[i] == 8'hFF) ? 8'hFF : sel_cnt[i] + 8'd1) : 8'd0;
   end

   always_comb begin
      bus.slv_ready = '0;
      bus.slv_rdata = '0;
      for (int i = 0; i < N; i++) begin
         bus.slv_ready[i] = (bus.slv_sel[i] && int'(sel_cnt[i]) >= wait_cfg[i]) || force_rdy[i];
         bus.slv_rdata[i*DW +: DW] = rdata_cfg[i];
      end
   end

   // Drives one request starting at the current cycle; returns at the cycle after data_ready.
   task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         input logic [31:0] exp_rd, output int lat, output logic [31:0] got,
                         output int sel_cycles, output logic [N-1:0] sel_or, output logic pass_ok);
      bus.data_sel   = 1'b1;
      bus.data_we    = we;
      bus.data_addr  = addr;
      bus.data_to_wr = wd;
      exp_q.push_back(exp_rd);
      lat = -1; got = '0; sel_cycles = 0; sel_or = '0; pass_ok = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.slv_we !== we || bus.slv_addr !== addr || bus.slv_wdata !== wd) pass_ok = 1'b0;
         if (bus.slv_sel != '0) begin
            sel_cycles++;
            sel_or |= bus.slv_sel;
         end
         if (bus.data_ready === 1'b1) begin
            lat = c;
            got = bus.data_to_rd;
            break;
         end
      end
      @(posedge clk); #1;
      bus.data_sel = 1'b0;
   endtask

   task automatic test_reset();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.data_ready); end
      total++; if (bus.data_to_rd !== '0) begin bad++; $display("FAIL rst_rd got=%h exp=0", bus.data_to_rd); end
      total++; if (bus.slv_sel !== '0) begin bad++; $display("FAIL rst_sel got=%b exp=0", bus.slv_sel); end
      @(posedge clk); #1;
      access(ERRA, 1'b0, 32'h0, 32'h0, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rst_errreg got=%h exp=%h", got, exp); end
      total++; if (lat !== 1) begin bad++; $display("FAIL rst_errlat got=%0d exp=1", lat); end
   endtask

   task automatic test_zero_wait();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      wait_cfg[2] = 0; rdata_cfg[2] = 32'hCAFE;
      access(32'h1A4, 1'b0, 32'h0, 32'hCAFE, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL zw_rd got=%h exp=%h", got, exp); end
      total++; if (lat !== 1) begin bad++; $display("FAIL zw_lat got=%0d exp=1", lat); end
      total++; if (sc !== 1 || so !== 4'b0100) begin bad++; $display("FAIL zw_sel got=%0d/%b exp=1/0100", sc, so); end
   endtask

   task automatic test_wait_write();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      wait_cfg[0] = 3; rdata_cfg[0] = 32'hDEAD_BEEF;
      access(32'h040, 1'b1, 32'h55, 32'h0, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL ww_rd got=%h exp=%h", got, exp); end
      total++; if (lat !== 4) begin bad++; $display("FAIL ww_lat got=%0d exp=4", lat); end
      total++; if (sc !== 4 || so !== 4'b0001) begin bad++; $display("FAIL ww_sel got=%0d/%b exp=4/0001", sc, so); end
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL ww_passthru got=%b exp=1", ok); end
   endtask

   task automatic test_unmapped_err();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      logic [31:0] addrs [8] = '{32'hF00, ERRA, 32'hE00, ERRA, ERRA, ERRA, 32'hD04, ERRA};
      logic        wes   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] exps  [8] = '{32'h0, 32'h8000_0F00, 32'h0, 32'h8000_0F00, 32'h0, 32'h0,
                                 32'h0, 32'h8000_0D04};
      for (int k = 0; k < 8; k++) begin
         access(addrs[k], wes[k], 32'h1234, exps[k], lat, got, sc, so, ok);
         exp = exp_q.pop_front();
         total++; if (got !== exp) begin bad++; $display("FAIL err_rd[%0d] got=%h exp=%h", k, got, exp); end
         total++; if (lat !== 1 || sc !== 0) begin bad++; $display("FAIL err_lat[%0d] got=%0d/%0d exp=1/0", k, lat, sc); end
      end
      access(ERRA, 1'b1, 32'h0, 32'h0, lat, got, sc, so, ok);
      void'(exp_q.pop_front());
   endtask

   task automatic test_priority();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      wait_cfg[1] = 2; rdata_cfg[1] = 32'h1111;
      wait_cfg[3] = 0; rdata_cfg[3] = 32'h3333;
      force_rdy = 4'b1000;
      access(32'h200, 1'b0, 32'h0, 32'h1111, lat, got, sc, so, ok);
      force_rdy = '0;
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL pri_rd got=%h exp=%h", got, exp); end
      total++; if (so !== 4'b0010) begin bad++; $display("FAIL pri_sel got=%b exp=0010", so); end
      total++; if (lat !== 3) begin bad++; $display("FAIL pri_lat got=%0d exp=3", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      longint t0;
      logic [31:0] addrs [3] = '{32'h1A4, ERRA, 32'h010};
      logic [31:0] exps  [3] = '{32'hCAFE, 32'h0, 32'h0A0A};
      wait_cfg[0] = 0; rdata_cfg[0] = 32'h0A0A;
      t0 = $time;
      for (int k = 0; k < 3; k++) begin
         access(addrs[k], 1'b0, 32'h0, exps[k], lat, got, sc, so, ok);
         exp = exp_q.pop_front();
         total++; if (got !== exp || lat !== 1) begin bad++; $display("FAIL b2b[%0d] got=%h/%0d exp=%h/1", k, got, lat, exp); end
      end
      total++; if ($time - t0 !== 60) begin bad++; $display("FAIL b2b_time got=%0d exp=60", $time - t0); end
   endtask

`ifdef XBUS_DEC_TIMEOUT_EN
   task automatic test_timeout();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      wait_cfg[1] = 255;
      access(32'h204, 1'b0, 32'h0, 32'h0, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL to_rd got=%h exp=%h", got, exp); end
      total++; if (lat !== 9 || sc !== 9) begin bad++; $display("FAIL to_lat got=%0d/%0d exp=9/9", lat, sc); end
      access(ERRA, 1'b0, 32'h0, 32'hC000_0204, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL to_errreg got=%h exp=%h", got, exp); end
      access(ERRA, 1'b1, 32'h0, 32'h0, lat, got, sc, so, ok);
      void'(exp_q.pop_front());
   endtask
`endif

   task automatic test_reset_mid();
      int lat, sc; logic [31:0] got, exp; logic [N-1:0] so; logic ok;
      logic held;
      access(32'hC00, 1'b0, 32'h0, 32'h0, lat, got, sc, so, ok);
      void'(exp_q.pop_front());
      wait_cfg[1] = 255;
      bus.data_sel = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h208;
      held = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.slv_sel !== 4'b0010 || bus.data_ready !== 1'b0) held = 1'b0;
      end
      total++; if (held !== 1'b1) begin bad++; $display("FAIL rm_wait got=%b exp=1", held); end
      @(posedge clk); #1;
      rst = 1'b1; bus.data_sel = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.slv_sel !== '0) begin bad++; $display("FAIL rm_sel got=%b exp=0", bus.slv_sel); end
      total++; if (bus.data_ready !== 1'b0 || bus.data_to_rd !== '0) begin bad++; $display("FAIL rm_ready got=%b/%h exp=0/0", bus.data_ready, bus.data_to_rd); end
      @(posedge clk); #1;
      access(ERRA, 1'b0, 32'h0, 32'h0, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL rm_errclr got=%h exp=%h", got, exp); end
      wait_cfg[1] = 0;
      access(32'h208, 1'b0, 32'h0, 32'h1111, lat, got, sc, so, ok);
      exp = exp_q.pop_front();
      total++; if (got !== exp || lat !== 1 || so !== 4'b0010) begin bad++; $display("FAIL rm_new got=%h/%0d/%b exp=%h/1/0010", got, lat, so, exp); end
   endtask

   initial begin
      rst = 1'b1;
      bus.data_sel = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_to_wr = '0;
      force_rdy = '0;
      for (int i = 0; i < N; i++) begin
         wait_cfg[i] = 0;
         rdata_cfg[i] = 32'h0;
      end
      test_reset();
      test_zero_wait();
      test_wait_write();
      test_unmapped_err();
      test_priority();
      test_back_to_back();
`ifdef XBUS_DEC_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
